// File: rtl/match_event_counter_pkg.sv
// Shared definitions for the match-level consumer: run-tracker FSM states and
// the upstream detector's symbol codes, so both ends agree on encodings.
package match_event_counter_pkg;

  localparam int unsigned SYM_W = 2;

  typedef enum logic [SYM_W-1:0] {
    SYM_0 = 2'b00,
    SYM_1 = 2'b01,
    SYM_2 = 2'b10,
    SYM_3 = 2'b11
  } sym_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/match_run_tracker.sv
// Follows the match level: flags each rising edge (evt), tracks the current
// run length and the longest run seen so far.
module match_run_tracker
  import match_event_counter_pkg::*;
#(
  parameter int unsigned RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match,
  input  logic             clr,
  output logic             evt,
  output logic [RUN_W-1:0] max_run,
  output logic             rise_c
);

  run_state_e       state, state_nxt;
  logic [RUN_W-1:0] run_len, run_len_nxt;
  logic [RUN_W-1:0] max_run_nxt;
  logic             evt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      run_len <= '0;
      max_run <= '0;
      evt     <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_len <= run_len_nxt;
      max_run <= max_run_nxt;
      evt     <= evt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    run_len_nxt = run_len;
    evt_nxt     = 1'b0;
    rise_c      = 1'b0;
    max_run_nxt = max_run;
    case (state)
      ST_IDLE: begin
        if (match) begin
          state_nxt   = ST_RUN;
          run_len_nxt = RUN_W'(1);
          evt_nxt     = 1'b1;
          rise_c      = 1'b1;
        end
      end
      ST_RUN: begin
        if (match) begin
          if (run_len != '1) run_len_nxt = run_len + RUN_W'(1);
        end else begin
          state_nxt   = ST_IDLE;
          run_len_nxt = '0;
        end
      end
    endcase
    // max follows an in-progress run; clear wins for this edge only
    if (clr) max_run_nxt = '0;
    else if (run_len_nxt > max_run) max_run_nxt = run_len_nxt;
  end

endmodule

// File: rtl/match_event_counter.sv
// Counts distinct detections of the match level, tracks the longest match run,
// and offers a req/valid/ack snapshot of both statistics.
module match_event_counter
  import match_event_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RUN_W = 8,
  parameter bit          WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match,
  input  logic             clr,
  output logic             evt,
  output logic [CNT_W-1:0] count,
  output logic [RUN_W-1:0] max_run,
  output logic             ovf,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_count,
  output logic [RUN_W-1:0] rd_max,
  input  logic             rd_ack
);

  logic rise_c;

  match_run_tracker #(.RUN_W(RUN_W)) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .match   (match),
    .clr     (clr),
    .evt     (evt),
    .max_run (max_run),
    .rise_c  (rise_c)
  );

  // Detection counter: saturate or wrap at all-ones, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (rise_c) begin
      if (count == '1) begin
        ovf <= 1'b1;
        if (WRAP) count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Snapshot captures pre-update register values; ack beats a coincident req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_count <= '0;
      rd_max   <= '0;
    end else if (!rd_valid) begin
      if (rd_req) begin
        rd_valid <= 1'b1;
        rd_count <= count;
        rd_max   <= max_run;
      end
    end else if (rd_ack) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_match_event_counter.sv
// Directed bench for match_event_counter (CNT_W=RUN_W=4), saturating and
// wrapping instances driven from the same stimulus.
module tb_match_event_counter;

  logic       clk, rst_n, match, clr, rd_req, rd_ack;
  logic       evt, ovf, rd_valid;
  logic [3:0] count, max_run, rd_count, rd_max;
  logic       evt_w, ovf_w, rd_valid_w;
  logic [3:0] count_w, max_run_w, rd_count_w, rd_max_w;

  int n_vec = 0;
  int n_err = 0;
  int evt_cnt = 0;

  match_event_counter #(.CNT_W(4), .RUN_W(4), .WRAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .match(match), .clr(clr),
    .evt(evt), .count(count), .max_run(max_run), .ovf(ovf),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_count(rd_count),
    .rd_max(rd_max), .rd_ack(rd_ack)
  );

  match_event_counter #(.CNT_W(4), .RUN_W(4), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .match(match), .clr(clr),
    .evt(evt_w), .count(count_w), .max_run(max_run_w), .ovf(ovf_w),
    .rd_req(rd_req), .rd_valid(rd_valid_w), .rd_count(rd_count_w),
    .rd_max(rd_max_w), .rd_ack(rd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it
  task automatic cyc();
    @(posedge clk);
    #1;
    if (evt) evt_cnt++;
  endtask

  task automatic run(input int len);
    match = 1'b1;
    for (int i = 0; i < len; i++) begin
      cyc();
      check("evt_in_run", 32'(evt), 32'(i == 0));
    end
    match = 1'b0;
    cyc();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    int e0;
    rst_n = 1'b0; match = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_count", 32'(count), 0);
    check("rst_max", 32'(max_run), 0);
    check("rst_evt", 32'(evt), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_count", 32'(rd_count), 0);
    check("rst_rd_max", 32'(rd_max), 0);

    // 1: async reset mid-run and mid-handshake
    match = 1'b1; rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    check("t1_count_pre", 32'(count), 1);
    check("t1_rd_valid_pre", 32'(rd_valid), 1);
    cyc();
    check("t1_max_pre", 32'(max_run), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_count", 32'(count), 0);
    check("t1_async_max", 32'(max_run), 0);
    check("t1_async_rd_valid", 32'(rd_valid), 0);
    check("t1_async_evt", 32'(evt), 0);
    match = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    e0 = evt_cnt;
    run(5);
    check("t1_evts", 32'(evt_cnt - e0), 1);
    check("t1_count", 32'(count), 1);
    check("t1_max", 32'(max_run), 5);

    // 2: three runs 2,7,3
    do_clr();
    check("t2_clr_count", 32'(count), 0);
    check("t2_clr_max", 32'(max_run), 0);
    e0 = evt_cnt;
    run(2); run(7); run(3);
    check("t2_count", 32'(count), 3);
    check("t2_max", 32'(max_run), 7);
    check("t2_evts", 32'(evt_cnt - e0), 3);

    // 3: overflow, saturate vs wrap
    do_clr();
    for (int i = 0; i < 15; i++) run(1);
    check("t3_sat_count15", 32'(count), 15);
    check("t3_sat_ovf15", 32'(ovf), 0);
    check("t3_wrap_count15", 32'(count_w), 15);
    check("t3_wrap_ovf15", 32'(ovf_w), 0);
    run(1);
    check("t3_sat_count", 32'(count), 15);
    check("t3_sat_ovf", 32'(ovf), 1);
    check("t3_wrap_count", 32'(count_w), 0);
    check("t3_wrap_ovf", 32'(ovf_w), 1);
    do_clr();
    check("t3_clr_ovf", 32'(ovf), 0);

    // 4: clr on the edge match rises
    for (int i = 0; i < 5; i++) run(1);
    check("t4_count5", 32'(count), 5);
    clr = 1'b1; match = 1'b1;
    cyc();
    clr = 1'b0;
    check("t4_clr_count", 32'(count), 0);
    check("t4_clr_evt", 32'(evt), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_held_count", 32'(count), 0);
    end
    match = 1'b0;
    cyc();
    check("t4_after_count", 32'(count), 0);
    check("t4_max", 32'(max_run), 4);
    run(1);
    check("t4_next_count", 32'(count), 1);

    // 5: snapshot frozen while valid
    do_clr();
    run(1); run(1); run(1);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    check("t5_rd_valid", 32'(rd_valid), 1);
    check("t5_rd_count", 32'(rd_count), 3);
    check("t5_rd_max", 32'(rd_max), 1);
    run(2); run(1);
    check("t5_count", 32'(count), 5);
    check("t5_rd_count_frozen", 32'(rd_count), 3);
    check("t5_rd_max_frozen", 32'(rd_max), 1);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    check("t5_req2_rd_count", 32'(rd_count), 3);
    do_clr();
    check("t5_clr_rd_valid", 32'(rd_valid), 1);
    check("t5_clr_rd_count", 32'(rd_count), 3);
    rd_ack = 1'b1;
    cyc();
    rd_ack = 1'b0;
    check("t5_ack_rd_valid", 32'(rd_valid), 0);
    rd_ack = 1'b1;
    cyc();
    rd_ack = 1'b0;
    check("t5_stray_ack", 32'(rd_valid), 0);

    // 6: req on an event edge, then ack+req together
    do_clr();
    run(1); run(1);
    match = 1'b1; rd_req = 1'b1;
    cyc();
    rd_req = 1'b0; match = 1'b0;
    check("t6_rd_count", 32'(rd_count), 2);
    check("t6_count", 32'(count), 3);
    check("t6_rd_valid", 32'(rd_valid), 1);
    cyc();
    rd_ack = 1'b1; rd_req = 1'b1;
    cyc();
    rd_ack = 1'b0; rd_req = 1'b0;
    check("t6_ackreq_rd_valid", 32'(rd_valid), 0);
    cyc();
    check("t6_no_new_snap", 32'(rd_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
